ola_trigger_loader: RTL and testbench
=====================================

// Module: ola_trigger_loader
// PURPOSE
//  Host-side driver for the trigger-state serial control interface. Takes one
//  parallel config command (state index, then/else, conditions/actions, word)
//  over a valid/ready handshake and shifts it LSB-first into the selected
//  trigger state's condition or action register. Sits between the
//  host/config decoder and the array of trigger-state blocks.
// PARAMETERS
//  num_states      4  trigger states driven; one ctl_enable bit each
//  state_bits      2  width of cmd_state; must satisfy 2**state_bits >= num_states
//  condition_width 4  bits per condition register; shift count for conditions
//  action_width    4  bits per action register; shift count for actions
//  word_width      4  cmd_word width; must be >= max(condition_width, action_width)
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           synchronous, active-low reset
//  cmd_valid      in   1           command present
//  cmd_ready      out  1           loader idle; accepts cmd when cmd_valid && cmd_ready
//  cmd_state      in   state_bits  target trigger state index
//  cmd_then       in   1           write the then-branch register
//  cmd_else       in   1           write the else-branch register
//  cmd_actions    in   1           0 = condition register, 1 = action register
//  cmd_clear      in   1           zero all four registers of cmd_state; overrides then/else/actions/word
//  cmd_word       in   word_width  value to load; bit 0 shifted first
//  ctl_enable     out  num_states  one-hot shift enable to target state
//  ctl_data       out  1           serial data bit
//  ctl_then       out  1           then-branch select
//  ctl_else       out  1           else-branch select
//  ctl_conditions out  1           condition-register select
//  ctl_actions    out  1           action-register select
//  busy           out  1           high in SHIFT and GAP
//  done           out  1           one-cycle pulse when a command completes
// BEHAVIOUR
//  - All outputs registered. While reset==0 at a clock edge: FSM->IDLE, all
//    ctl_* = 0, busy = 0, done = 0, bit counter = 0. cmd_ready = 1 in IDLE only.
//  - FSM IDLE -> SHIFT -> GAP -> IDLE. Accept on cmd_valid && cmd_ready; the
//    command fields are latched at the accepting edge.
//  - Shift length N: cmd_clear -> max(condition_width, action_width);
//    cmd_actions=1 -> action_width; else condition_width.
//  - SHIFT, cycle k = 0..N-1 (first cycle follows the accept edge):
//    ctl_enable = 1 << cmd_state; ctl_data = word[k] (0 for clear);
//    ctl_then/ctl_else = latched cmd_then/cmd_else;
//    ctl_conditions = !cmd_actions, ctl_actions = cmd_actions;
//    clear sets then = else = conditions = actions = 1, data = 0.
//  - GAP: exactly one cycle, every ctl_* = 0, done = 1. Next cycle IDLE.
//    Command period is N+2 cycles.
//  - After N shifts, bit 0 of the word sits in bit 0 of the receiver
//    register (receiver shifts MSB-in, right).
//  - No-target command (cmd_then = cmd_else = 0 and not clear), or
//    cmd_state >= num_states: accepted; SHIFT is skipped; ctl_enable stays
//    0; the next cycle is GAP with done = 1.
//  - cmd_word bits at or above N are ignored.
//  - cmd_valid with cmd_ready = 0 is ignored; the caller holds it.
//  - Reset mid-SHIFT: ctl_* drop to 0 the next cycle. The partially shifted
//    register is not repaired; the host must reissue the command.
//  - ctl_enable falls for at least one cycle (GAP) between commands.
// TESTING
//  - Load cond: state=2, then=1, actions=0, word=4'b1011 -> ctl_enable=4'b0100
//    for 4 cycles, data 1,1,0,1; receiver then_conditions=4'b1011; done at cycle 5.
//  - Load both: then=else=1, actions=1, word=4'b0110 -> then_actions =
//    else_actions = 4'b0110; conditions unchanged.
//  - Clear: state=1 after loading 4'hF into all regs -> 4 cycles data=0, all
//    selects 1; all four regs = 0; out_act = 0.
//  - Back-to-back: cmd_valid held high for 2 cmds -> second accepted exactly
//    6 cycles after the first; one idle ctl_enable cycle between them.
//  - Invalid: state=3 with num_states=3, or then=else=0 -> no ctl_enable;
//    done one cycle after accept; ready the following cycle.
//  - Reset low at SHIFT cycle 2 -> next cycle all ctl_* = 0, busy = 0,
//    cmd_ready = 1 after release.

Source files
------------

// File: rtl/ola_trigger_loader_if.sv
// rtl/ola_trigger_loader_if.sv - config command handshake bus into the trigger loader
interface ola_trigger_loader_if #(
  parameter int state_bits = 2,
  parameter int word_width = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [state_bits-1:0] cmd_state;
  logic                  cmd_then;
  logic                  cmd_else;
  logic                  cmd_actions;
  logic                  cmd_clear;
  logic [word_width-1:0] cmd_word;

  modport master (
    output cmd_valid, cmd_state, cmd_then, cmd_else, cmd_actions, cmd_clear, cmd_word,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_state, cmd_then, cmd_else, cmd_actions, cmd_clear, cmd_word,
    output cmd_ready
  );
endinterface

// File: rtl/ola_trigger_loader.sv
// rtl/ola_trigger_loader.sv - shifts one parallel config command LSB-first into a trigger state
// register over the serial control interface; IDLE -> SHIFT (N cycles) -> GAP -> IDLE.
module ola_trigger_loader #(
  parameter int num_states      = 4,
  parameter int state_bits      = 2,
  parameter int condition_width = 4,
  parameter int action_width    = 4,
  parameter int word_width      = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  ola_trigger_loader_if.slave   cmd,
  output logic [num_states-1:0] ctl_enable_o,
  output logic                  ctl_data_o,
  output logic                  ctl_then_o,
  output logic                  ctl_else_o,
  output logic                  ctl_conditions_o,
  output logic                  ctl_actions_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int max_width = (condition_width > action_width) ? condition_width : action_width;
  localparam int cnt_bits  = $clog2(max_width + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [cnt_bits-1:0]   cnt_q, cnt_d;
  logic [cnt_bits-1:0]   len_q, len_d;
  logic [word_width-1:0] word_q, word_d;
  logic [num_states-1:0] enable_q, enable_d;
  logic                  data_q, data_d;
  logic                  then_q, then_d;
  logic                  else_q, else_d;
  logic                  cond_q, cond_d;
  logic                  act_q, act_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;

  logic [num_states-1:0] onehot;
  logic                  target_ok;
  logic [cnt_bits-1:0]   new_len;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < num_states; i++) begin
      onehot[i] = (int'(cmd.cmd_state) == i);
    end
    // Out-of-range states and commands selecting no branch still handshake but never shift.
    target_ok = (int'(cmd.cmd_state) < num_states) &&
                (cmd.cmd_clear || cmd.cmd_then || cmd.cmd_else);
    if (cmd.cmd_clear)        new_len = cnt_bits'(max_width);
    else if (cmd.cmd_actions) new_len = cnt_bits'(action_width);
    else                      new_len = cnt_bits'(condition_width);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    word_d   = word_q;
    enable_d = enable_q;
    data_d   = data_q;
    then_d   = then_q;
    else_d   = else_q;
    cond_d   = cond_q;
    act_d    = act_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (target_ok) begin
            state_d  = ST_SHIFT;
            enable_d = onehot;
            data_d   = cmd.cmd_clear ? 1'b0 : cmd.cmd_word[0];
            word_d   = cmd.cmd_clear ? '0 : (cmd.cmd_word >> 1);
            then_d   = cmd.cmd_clear | cmd.cmd_then;
            else_d   = cmd.cmd_clear | cmd.cmd_else;
            cond_d   = cmd.cmd_clear | ~cmd.cmd_actions;
            act_d    = cmd.cmd_clear | cmd.cmd_actions;
            cnt_d    = cnt_bits'(1);
            len_d    = new_len;
          end else begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == len_q) begin
          state_d  = ST_GAP;
          enable_d = '0;
          data_d   = 1'b0;
          then_d   = 1'b0;
          else_d   = 1'b0;
          cond_d   = 1'b0;
          act_d    = 1'b0;
          done_d   = 1'b1;
        end else begin
          data_d = word_q[0];
          word_d = word_q >> 1;
          cnt_d  = cnt_q + cnt_bits'(1);
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      word_q   <= '0;
      enable_q <= '0;
      data_q   <= 1'b0;
      then_q   <= 1'b0;
      else_q   <= 1'b0;
      cond_q   <= 1'b0;
      act_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      word_q   <= word_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      then_q   <= then_d;
      else_q   <= else_d;
      cond_q   <= cond_d;
      act_q    <= act_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd.cmd_ready      = ready_q;
  assign ctl_enable_o       = enable_q;
  assign ctl_data_o         = data_q;
  assign ctl_then_o         = then_q;
  assign ctl_else_o         = else_q;
  assign ctl_conditions_o   = cond_q;
  assign ctl_actions_o      = act_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_ola_trigger_loader.sv
// tb/tb_ola_trigger_loader.sv - directed self-checking bench with a serial receiver model
`timescale 1ns/1ps
module tb_ola_trigger_loader;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] ctl_enable;
  logic          ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  logic [3:0] rx_tc [NS];
  logic [3:0] rx_ta [NS];
  logic [3:0] rx_ec [NS];
  logic [3:0] rx_ea [NS];

  ola_trigger_loader_if #(.state_bits(2), .word_width(4)) cmd_if ();

  ola_trigger_loader #(
    .num_states(NS), .state_bits(2), .condition_width(4), .action_width(4), .word_width(4)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .cmd(cmd_if.slave),
    .ctl_enable_o(ctl_enable), .ctl_data_o(ctl_data), .ctl_then_o(ctl_then),
    .ctl_else_o(ctl_else), .ctl_conditions_o(ctl_cond), .ctl_actions_o(ctl_act),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: each selected register shifts right with the serial bit entering at the MSB.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (ctl_enable[s]) begin
        if (ctl_then && ctl_cond) rx_tc[s] <= {ctl_data, rx_tc[s][3:1]};
        if (ctl_then && ctl_act)  rx_ta[s] <= {ctl_data, rx_ta[s][3:1]};
        if (ctl_else && ctl_cond) rx_ec[s] <= {ctl_data, rx_ec[s][3:1]};
        if (ctl_else && ctl_act)  rx_ea[s] <= {ctl_data, rx_ea[s][3:1]};
      end
    end
  end

  task automatic drive(input logic [1:0] st, input logic th, input logic el,
                       input logic ac, input logic cl, input logic [3:0] w);
    cmd_if.cmd_state   = st;
    cmd_if.cmd_then    = th;
    cmd_if.cmd_else    = el;
    cmd_if.cmd_actions = ac;
    cmd_if.cmd_clear   = cl;
    cmd_if.cmd_word    = w;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic send(input logic [1:0] st, input logic th, input logic el,
                      input logic ac, input logic cl, input logic [3:0] w);
    int n;
    drive(st, th, el, ac, cl, w);
    cmd_if.cmd_valid = 1'b1;
    n = 0;
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_if.cmd_ready);
    end
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: cmd_ready=%b required 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done, cmd_if.cmd_ready}
        !== {3'b000, 7'b0000000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: en=%b d=%b t=%b e=%b c=%b a=%b busy=%b done=%b rdy=%b required all 0, rdy=1",
               ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done, cmd_if.cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, cmd_if.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL after_release: busy=%b done=%b rdy=%b required 0 0 1", busy, done, cmd_if.cmd_ready);
    end
  endtask

  task automatic test_load_cond();
    logic [3:0] w;
    w = 4'b1011;
    send(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, w);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done, cmd_if.cmd_ready}
          !== {3'b100, w[k], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL cond_shift_%0d: en=%b d=%b t=%b e=%b c=%b a=%b busy=%b done=%b required en=100 d=%b t=1 e=0 c=1 a=0 busy=1 done=0",
                 k, ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done, w[k]);
      end
      @(negedge clk);
    end
    checks++;
    if ({ctl_enable, ctl_then, ctl_cond, done, busy, cmd_if.cmd_ready} !== {3'b000, 5'b00110}) begin
      errors++;
      $display("FAIL cond_gap: en=%b t=%b c=%b done=%b busy=%b rdy=%b required en=000 t=0 c=0 done=1 busy=1 rdy=0",
               ctl_enable, ctl_then, ctl_cond, done, busy, cmd_if.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, cmd_if.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL cond_idle: done=%b busy=%b rdy=%b required 0 0 1", done, busy, cmd_if.cmd_ready);
    end
    checks++;
    if (rx_tc[2] !== 4'b1011) begin
      errors++;
      $display("FAIL cond_rx: then_conditions=%b required 1011", rx_tc[2]);
    end
  endtask

  task automatic test_load_both();
    send(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
    wait_idle();
    checks++;
    if ({rx_ta[0], rx_ea[0], rx_tc[0], rx_ec[0]} !== {4'b0110, 4'b0110, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL both_rx: ta=%b ea=%b tc=%b ec=%b required 0110 0110 0000 0000",
               rx_ta[0], rx_ea[0], rx_tc[0], rx_ec[0]);
    end
  endtask

  task automatic test_clear();
    send(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
    wait_idle();
    send(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
    wait_idle();
    checks++;
    if ({rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]} !== 16'hFFFF) begin
      errors++;
      $display("FAIL clear_preload: regs=%h required ffff", {rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]});
    end
    send(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act} !== {3'b010, 5'b01111}) begin
        errors++;
        $display("FAIL clear_shift_%0d: en=%b d=%b t=%b e=%b c=%b a=%b required en=010 d=0 t=e=c=a=1",
                 k, ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act);
      end
      @(negedge clk);
    end
    checks++;
    if ({ctl_enable, done} !== 4'b0001) begin
      errors++;
      $display("FAIL clear_gap: en=%b done=%b required 000 1", ctl_enable, done);
    end
    wait_idle();
    checks++;
    if ({rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]} !== 16'h0000) begin
      errors++;
      $display("FAIL clear_rx: regs=%h required 0000", {rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]});
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, n, idle_en;
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    drive(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001);
    n = 0;
    idle_en = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 20) begin
      if (ctl_enable == 3'b000) idle_en++;
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 t1 = cyc;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    wait_idle();
    checks++;
    if (t1 - t0 !== 6) begin
      errors++;
      $display("FAIL b2b_period: accept spacing=%0d required 6", t1 - t0);
    end
    checks++;
    if (idle_en !== 1) begin
      errors++;
      $display("FAIL b2b_gap: idle enable cycles=%0d required 1", idle_en);
    end
    checks++;
    if ({rx_ec[0], rx_ea[2]} !== {4'b0101, 4'b1001}) begin
      errors++;
      $display("FAIL b2b_rx: ec0=%b ea2=%b required 0101 1001", rx_ec[0], rx_ea[2]);
    end
  endtask

  task automatic test_invalid();
    logic [1:0] st [2];
    logic       th [2];
    st[0] = 2'd3; th[0] = 1'b1;
    st[1] = 2'd1; th[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(st[i], th[i], 1'b0, 1'b0, 1'b0, 4'b1111);
      checks++;
      if ({ctl_enable, done, busy, cmd_if.cmd_ready} !== {3'b000, 3'b110}) begin
        errors++;
        $display("FAIL invalid_%0d_gap: en=%b done=%b busy=%b rdy=%b required 000 1 1 0",
                 i, ctl_enable, done, busy, cmd_if.cmd_ready);
      end
      @(negedge clk);
      checks++;
      if ({ctl_enable, done, cmd_if.cmd_ready} !== {3'b000, 2'b01}) begin
        errors++;
        $display("FAIL invalid_%0d_ready: en=%b done=%b rdy=%b required 000 0 1",
                 i, ctl_enable, done, cmd_if.cmd_ready);
      end
    end
    checks++;
    if ({rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]} !== 16'h0000) begin
      errors++;
      $display("FAIL invalid_rx: regs=%h required 0000", {rx_tc[1], rx_ta[1], rx_ec[1], rx_ea[1]});
    end
  endtask

  task automatic test_reset_mid_shift();
    send(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid: en=%b d=%b t=%b e=%b c=%b a=%b busy=%b done=%b required all 0",
               ctl_enable, ctl_data, ctl_then, ctl_else, ctl_cond, ctl_act, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_if.cmd_ready, busy, ctl_enable} !== {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b busy=%b en=%b required 1 0 000",
               cmd_if.cmd_ready, busy, ctl_enable);
    end
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      rx_tc[s] = '0; rx_ta[s] = '0; rx_ec[s] = '0; rx_ea[s] = '0;
    end
    cmd_if.cmd_valid = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    test_reset();
    test_load_cond();
    test_load_both();
    test_clear();
    test_back_to_back();
    test_invalid();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
